// File: rtl/mat_tile_loader_pkg.sv
// mat_tile_loader_pkg: types and constants shared by the tile loader,
// its memory interface and its read-latency pipeline.
//   mem_t   - memory request word (read, write, address, writedata)
//   word_t  - one memory word = one tile row of BANDWIDTH elements
//   tile_t  - TILE_DIM x TILE_DIM tile of DATA_WIDTH elements, tile[r][c]
//   state_t - loader FSM states
package mat_tile_loader_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DIM_WIDTH  = 8;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned TILE_DIM   = 8;
  // One memory word carries exactly one tile row.
  localparam int unsigned BANDWIDTH  = TILE_DIM;
  localparam int unsigned ROW_W      = $clog2(TILE_DIM);

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] word_t;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    word_t                 writedata;
  } mem_t;

  typedef logic [TILE_DIM-1:0][TILE_DIM-1:0][DATA_WIDTH-1:0] tile_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam row_t LAST_ROW = row_t'(TILE_DIM - 1);

endpackage

// File: rtl/mat_tile_loader_if.sv
// mat_tile_loader_if: memory bus between the tile loader and memory.
//   memX     - request from the loader (master drives)
//   readdata - read word returning from memory (slave drives)
interface mat_tile_loader_if;
  import mat_tile_loader_pkg::*;

  mem_t  memX;
  word_t readdata;

  modport master (output memX, input readdata);
  modport slave  (input memX, output readdata);
endinterface

// File: rtl/mat_tile_loader_rd_pipe.sv
// tile_rd_pipe: READ_LATENCY-deep valid/row-index shift pipeline. A read
// issued in cycle c appears on out_valid/out_row in cycle c+READ_LATENCY,
// the cycle its readdata is on the bus.
//   clock, reset       - clock, synchronous active-high reset (clears pipe)
//   in_valid, in_row   - read issued this cycle and its tile row
//   out_valid, out_row - readdata for out_row is valid this cycle
module tile_rd_pipe
  import mat_tile_loader_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  row_t in_row,
  output logic out_valid,
  output row_t out_row
);

  localparam int unsigned IW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  logic [READ_LATENCY-1:0]       vld;
  row_t [READ_LATENCY-1:0]       rows;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld  <= '0;
      rows <= '0;
    end else begin
      vld[0]  <= in_valid;
      rows[0] <= in_row;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld[IW'(i)]  <= vld[IW'(i - 1)];
        rows[IW'(i)] <= rows[IW'(i - 1)];
      end
    end
  end

  assign out_valid = vld[IW'(READ_LATENCY - 1)];
  assign out_row   = rows[IW'(READ_LATENCY - 1)];

endmodule

// File: rtl/mat_tile_loader.sv
// mat_tile_loader: fetches one 8x8 tile as eight row reads at
// base_addr + r*stride (modulo 2^ADDR_WIDTH) and captures it into tile.
// Optional feature macro: TILE_TRANSPOSE_EN adds a transpose input, latched
// on start; when set, element c of row r is stored to tile[c][r].
//   clock, reset    - clock, synchronous active-high reset
//   start           - one-cycle fetch request, accepted only in IDLE
//   base_addr       - word address of tile row 0 (latched on start)
//   stride          - word distance between rows (latched on start)
//   transpose       - (TILE_TRANSPOSE_EN only) store transposed
//   bus             - memory master: memX request, readdata return
//   busy            - fetch in progress
//   done            - one-cycle pulse, tile complete
//   tile            - captured tile, held until overwritten by a new fetch
module mat_tile_loader
  import mat_tile_loader_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_WIDTH-1:0]  stride,
`ifdef TILE_TRANSPOSE_EN
  input  logic                  transpose,
`endif
  mat_tile_loader_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output tile_t                 tile
);

  state_t                state;
  logic                  rd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DIM_WIDTH-1:0]  stride_q;
  row_t                  issue_row;
  logic                  cap_valid;
  row_t                  cap_row;
`ifdef TILE_TRANSPOSE_EN
  logic                  tr_q;
`endif

  assign bus.memX = '{read: rd_q, write: 1'b0, address: addr_q, writedata: '0};

  // addr_q starts at the latched base and steps by the latched stride, so
  // the base needs no separate latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      stride_q  <= '0;
      issue_row <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef TILE_TRANSPOSE_EN
      tr_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            rd_q      <= 1'b1;
            addr_q    <= base_addr;
            stride_q  <= stride;
            issue_row <= '0;
            busy      <= 1'b1;
`ifdef TILE_TRANSPOSE_EN
            tr_q      <= transpose;
`endif
          end
        end
        ISSUE: begin
          if (issue_row == LAST_ROW) begin
            rd_q  <= 1'b0;
            state <= DRAIN;
          end else begin
            issue_row <= issue_row + row_t'(1);
            addr_q    <= addr_q + ADDR_WIDTH'(stride_q);
          end
        end
        DRAIN: begin
          if (cap_valid && cap_row == LAST_ROW) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tile_rd_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (rd_q),
    .in_row    (issue_row),
    .out_valid (cap_valid),
    .out_row   (cap_row)
  );

  // Capture follows the latency pipeline only, independent of FSM state.
  always_ff @(posedge clock) begin
    if (reset) begin
      tile <= '0;
    end else if (cap_valid) begin
`ifdef TILE_TRANSPOSE_EN
      if (tr_q) begin
        for (int unsigned c = 0; c < TILE_DIM; c++) begin
          tile[row_t'(c)][cap_row] <= bus.readdata[row_t'(c)];
        end
      end else begin
        tile[cap_row] <= bus.readdata;
      end
`else
      tile[cap_row] <= bus.readdata;
`endif
    end
  end

endmodule

// File: doc/mat_tile_loader.md
MAT_TILE_LOADER -- requirements
Module: mat_tile_loader

Interface
REQ-001 Parameter READ_LATENCY, default 2: cycles from a read request (memX.read high) to valid readdata; legal range 1..4.
REQ-002 clock  input  1  single clock; all state on its rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 start  input  1  one-cycle request to fetch one 8x8 tile.
REQ-005 base_addr  input  `ADDR_WIDTH  word address of tile row 0.
REQ-006 stride  input  `DIM_WIDTH  word distance between consecutive tile rows (matrix width in 8-blocks).
REQ-007 readdata  input  [`BANDWIDTH-1:0][`DATA_WIDTH-1:0]  memory read word, one tile row.
REQ-008 memX  output  mem_t  memory request; write=0 and writedata=0 always.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse; tile valid.
REQ-011 tile  output  [7:0][7:0][`DATA_WIDTH-1:0]  captured tile, held until the next accepted start.

Function
REQ-012 `BANDWIDTH SHALL equal 8; one memory word is one tile row.
REQ-013 FSM states IDLE, ISSUE, DRAIN; IDLE->ISSUE on start, ISSUE->DRAIN after 8th read, DRAIN->IDLE when the last row is captured.
REQ-014 start is accepted only in IDLE; start while busy SHALL be ignored with no effect on base_addr/stride latches.
REQ-015 base_addr and stride are latched on accepted start; later input changes have no effect on the fetch in progress.
REQ-016 If start is accepted in cycle t, memX.read is high in cycles t+1..t+8 with memX.address = base + r*stride for r = 0..7.
REQ-017 Address arithmetic is modulo 2^`ADDR_WIDTH (wrap-around, no error).
REQ-018 stride = 0 SHALL read base eight times.
REQ-019 readdata in cycle t+1+r+READ_LATENCY is captured into tile[r] at the end of that cycle.
REQ-020 done is high in cycle t+9+READ_LATENCY only; busy falls in the same cycle.
REQ-021 Rows are tracked by a READ_LATENCY-deep valid/row-index shift pipeline; capture never depends on the FSM state.
REQ-022 Only one fetch is outstanding; a new start is accepted no earlier than the cycle done is high.
REQ-023 Start in the done cycle is accepted; tile retains the old data until the new row 0 is captured.

Reset
REQ-024 Reset in any state forces IDLE, memX.read=0, address=0, busy=0, done=0, tile=0, and clears the capture pipeline.
REQ-025 Reset mid-fetch discards in-flight reads; readdata returning after reset is not captured.

Configuration
REQ-026 Macro TILE_TRANSPOSE_EN: when defined, an input transpose (1 bit) is latched on start; when 1, element c of row r is stored to tile[c][r].
REQ-027 Without TILE_TRANSPOSE_EN, the transpose port does not exist and tile[r][c] = row r element c always.

Structure
REQ-028 tile_t (8x8 of `DATA_WIDTH) and the TILE_DIM=8 constant belong in the shared Macro.svh package alongside mem_t.
REQ-029 The latency tracker is the sub-module tile_rd_pipe (parameter READ_LATENCY; in: issue valid, row index; out: capture valid, row index).

Verification
REQ-030 READ_LATENCY=2, base=0x100, stride=4, start at t=0 -> addresses 0x100,0x104,...,0x11C in cycles 1..8; done at cycle 11; tile[r][c] matches memory model.
REQ-031 Stride 0, base=0x20 -> eight reads of 0x20; all eight tile rows equal.
REQ-032 base = 2^`ADDR_WIDTH-2, stride=1 -> addresses wrap to 0..5 after the top two.
REQ-033 start pulsed again in cycle 4 with a different base -> ignored; original addresses and done at cycle 11 unchanged.
REQ-034 Reset asserted in cycle 6 -> next cycle read=0, busy=0, tile=0; no done; late readdata not captured.
REQ-035 With TILE_TRANSPOSE_EN, transpose=1, memory row r = {r*8+c} -> tile[c][r] = r*8+c; back-to-back start in done cycle fetches correctly.
